// File: rtl/dca_matrix_store_row_writer.sv
// Store-side row writer: pops one matrix's tensor rows per instruction and
// issues one addressed memory write per row through a single-entry output register.
module dca_matrix_store_row_writer #(
  parameter int MATRIX_SIZE_PARA = 8,
  parameter int BW_TENSOR_SCALAR = 32,
  parameter int BW_ADDR          = 32
) (
  input  logic                                         clk,
  input  logic                                         rstnn,
  input  logic                                         clear,
  input  logic                                         enable,
  output logic                                         busy,
  input  logic                                         inst_wvalid,
  output logic                                         inst_wready,
  input  logic [BW_ADDR-1:0]                           inst_addr,
  input  logic [BW_ADDR-1:0]                           inst_stride,
  input  logic [$clog2(MATRIX_SIZE_PARA):0]            inst_num_row,
  input  logic                                         store_tensor_row_rready,
  output logic                                         store_tensor_row_rvalid,
  output logic                                         store_tensor_row_rlast,
  input  logic [MATRIX_SIZE_PARA*BW_TENSOR_SCALAR-1:0] store_tensor_row_rdata,
  output logic                                         mem_wvalid,
  input  logic                                         mem_wready,
  output logic [BW_ADDR-1:0]                           mem_waddr,
  output logic [MATRIX_SIZE_PARA*BW_TENSOR_SCALAR-1:0] mem_wdata,
  output logic                                         done
);

  localparam int unsigned BW_TENSOR_ROW = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR;
  localparam int unsigned BW_NUM_ROW    = $clog2(MATRIX_SIZE_PARA) + 1;
  localparam logic [BW_NUM_ROW-1:0] MAX_ROW = BW_NUM_ROW'(MATRIX_SIZE_PARA);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  logic                     r_mem_wvalid;
  logic [BW_ADDR-1:0]       r_mem_waddr;
  logic [BW_TENSOR_ROW-1:0] r_mem_wdata;
  logic [BW_ADDR-1:0]       r_cur_addr;
  logic [BW_ADDR-1:0]       r_stride;
  logic [BW_NUM_ROW-1:0]    r_num_row;
  logic [BW_NUM_ROW-1:0]    r_row_cnt;

  logic                     w_accept;
  logic                     w_hs;
  logic                     w_pop;
  logic                     w_last;
  logic [BW_NUM_ROW-1:0]    w_num_row_eff;

  // Requests beyond the matrix size are clamped to a full matrix.
  assign w_num_row_eff = (inst_num_row > MAX_ROW) ? MAX_ROW : inst_num_row;

  assign inst_wready = rstnn & ~clear & enable & (r_state == S_IDLE);
  assign w_accept    = inst_wvalid & inst_wready;
  assign w_hs        = r_mem_wvalid & mem_wready;
  // A pop needs room in the output register, either empty or draining this cycle.
  assign w_pop       = rstnn & ~clear & enable & (r_state == S_RUN) &
                       store_tensor_row_rready & (~r_mem_wvalid | mem_wready);
  assign w_last      = (r_row_cnt == (r_num_row - BW_NUM_ROW'(1)));

  assign store_tensor_row_rvalid = w_pop;
  assign store_tensor_row_rlast  = w_pop & w_last;
  assign busy                    = rstnn & (r_state != S_IDLE);
  assign done                    = rstnn & ~clear & (r_state == S_DONE);
  assign mem_wvalid              = r_mem_wvalid;
  assign mem_waddr               = r_mem_waddr;
  assign mem_wdata               = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      r_state      <= S_IDLE;
      r_mem_wvalid <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_cur_addr   <= '0;
      r_stride     <= '0;
      r_num_row    <= '0;
      r_row_cnt    <= '0;
    end else if (clear) begin
      r_state      <= S_IDLE;
      r_mem_wvalid <= 1'b0;
      r_row_cnt    <= '0;
    end else begin
      // Output register: a pop reloads it even when a handshake drains it.
      if (w_pop) begin
        r_mem_wvalid <= 1'b1;
        r_mem_waddr  <= r_cur_addr;
        r_mem_wdata  <= store_tensor_row_rdata;
        r_cur_addr   <= r_cur_addr + r_stride;
        r_row_cnt    <= r_row_cnt + BW_NUM_ROW'(1);
      end else if (w_hs) begin
        r_mem_wvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cur_addr <= inst_addr;
            r_stride   <= inst_stride;
            r_num_row  <= w_num_row_eff;
            r_row_cnt  <= '0;
            r_state    <= (w_num_row_eff == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop && w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (enable && (!r_mem_wvalid || mem_wready)) r_state <= S_DONE;
        end
        S_DONE: begin
          if (enable) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dca_matrix_store_row_writer.sv
// Directed bench for dca_matrix_store_row_writer: basic store, back-pressure,
// upstream gaps, edge counts, and enable/clear/reset mid-operation.
module tb_dca_matrix_store_row_writer;

  logic         clk;
  logic         rstnn;
  logic         clear;
  logic         enable;
  logic         busy;
  logic         inst_wvalid;
  logic         inst_wready;
  logic [31:0]  inst_addr;
  logic [31:0]  inst_stride;
  logic [3:0]   inst_num_row;
  logic         store_tensor_row_rready;
  logic         store_tensor_row_rvalid;
  logic         store_tensor_row_rlast;
  logic [255:0] store_tensor_row_rdata;
  logic         mem_wvalid;
  logic         mem_wready;
  logic [31:0]  mem_waddr;
  logic [255:0] mem_wdata;
  logic         done;

  int vectors;
  int miscompares;

  dca_matrix_store_row_writer #(
    .MATRIX_SIZE_PARA (8),
    .BW_TENSOR_SCALAR (32),
    .BW_ADDR          (32)
  ) dut (
    .clk                     (clk),
    .rstnn                   (rstnn),
    .clear                   (clear),
    .enable                  (enable),
    .busy                    (busy),
    .inst_wvalid             (inst_wvalid),
    .inst_wready             (inst_wready),
    .inst_addr               (inst_addr),
    .inst_stride             (inst_stride),
    .inst_num_row            (inst_num_row),
    .store_tensor_row_rready (store_tensor_row_rready),
    .store_tensor_row_rvalid (store_tensor_row_rvalid),
    .store_tensor_row_rlast  (store_tensor_row_rlast),
    .store_tensor_row_rdata  (store_tensor_row_rdata),
    .mem_wvalid              (mem_wvalid),
    .mem_wready              (mem_wready),
    .mem_waddr               (mem_waddr),
    .mem_wdata               (mem_wdata),
    .done                    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] row_data(input logic [7:0] tag, input int k);
    logic [255:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = {tag, 8'(k), 8'(j), 8'h5A};
    return v;
  endfunction

  task automatic chk1(input logic act, input logic exp, input string name);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input logic [31:0] act, input logic [31:0] exp, input string name);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkw(input logic [255:0] act, input logic [255:0] exp, input string name);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, act, exp);
    end
  endtask

  // Cycle 0 of an instruction: offer it and confirm it is taken.
  task automatic start_inst(input logic [31:0] a, input logic [31:0] s, input logic [3:0] n);
    inst_wvalid  = 1'b1;
    inst_addr    = a;
    inst_stride  = s;
    inst_num_row = n;
    enable       = 1'b1;
    store_tensor_row_rready = 1'b1;
    mem_wready   = 1'b1;
    @(negedge clk);
    chk1(inst_wready, 1'b1, "inst_wready_idle");
    chk1(busy, 1'b0, "busy_idle");
    @(posedge clk); #1;
    inst_wvalid  = 1'b0;
    inst_addr    = '0;
    inst_stride  = '0;
    inst_num_row = '0;
  endtask

  // One full instruction with cycle-by-cycle checks of pops and write requests.
  // wr_mode 1: mem_wready 1,0,0,1 repeating; rd_mode 1: rready every other cycle;
  // en_mode 1: enable low in cycles 4..6.
  task automatic run_store(input logic [31:0] base, input logic [31:0] stride,
                           input logic [3:0] nrow, input int exp_rows, input int exp_done,
                           input int wr_mode, input int rd_mode, input int en_mode,
                           input logic [7:0] tag);
    int pops;
    int writes;
    int done_cyc;
    logic [31:0] exp_addr;
    pops     = 0;
    writes   = 0;
    done_cyc = -1;
    start_inst(base, stride, nrow);
    for (int cyc = 1; cyc < 80 && done_cyc < 0; cyc++) begin
      enable = !(en_mode == 1 && cyc >= 4 && cyc <= 6);
      store_tensor_row_rready = (rd_mode == 1) ? (cyc % 2 == 1) : 1'b1;
      mem_wready = (wr_mode == 1) ? ((cyc - 1) % 4 == 0 || (cyc - 1) % 4 == 3) : 1'b1;
      store_tensor_row_rdata = row_data(tag, pops);
      @(negedge clk);
      chk1(busy, 1'b1, "busy_run");
      if (store_tensor_row_rvalid) begin
        chk1(store_tensor_row_rready & enable, 1'b1, "rvalid_qualified");
        chk1(mem_wvalid & ~mem_wready, 1'b0, "pop_while_full");
        chk1(store_tensor_row_rlast, pops == exp_rows - 1, "rlast");
        pops++;
      end else begin
        chk1(store_tensor_row_rlast, 1'b0, "rlast_no_pop");
      end
      if (mem_wvalid) begin
        exp_addr = base + 32'(writes) * stride;
        chk32(mem_waddr, exp_addr, "mem_waddr");
        chkw(mem_wdata, row_data(tag, writes), "mem_wdata");
        if (mem_wready) writes++;
      end
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    chk1(done_cyc >= 0, 1'b1, "done_seen");
    if (exp_done > 0) chk32(32'(done_cyc), 32'(exp_done), "done_cycle");
    chk32(32'(pops), 32'(exp_rows), "pop_count");
    chk32(32'(writes), 32'(exp_rows), "write_count");
    enable = 1'b1;
    store_tensor_row_rready = 1'b0;
    mem_wready = 1'b1;
    @(negedge clk);
    chk1(busy, 1'b0, "busy_after_done");
    chk1(inst_wready, 1'b1, "inst_wready_after_done");
    chk1(done, 1'b0, "done_one_cycle");
    @(posedge clk); #1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rstnn        = 1'b0;
    clear        = 1'b0;
    enable       = 1'b1;
    inst_wvalid  = 1'b0;
    inst_addr    = '0;
    inst_stride  = '0;
    inst_num_row = '0;
    store_tensor_row_rready = 1'b0;
    store_tensor_row_rdata  = '0;
    mem_wready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk1(busy, 1'b0, "rst_busy");
    chk1(inst_wready, 1'b0, "rst_inst_wready");
    chk1(store_tensor_row_rvalid, 1'b0, "rst_rvalid");
    chk1(mem_wvalid, 1'b0, "rst_mem_wvalid");
    chk32(mem_waddr, 32'h0, "rst_mem_waddr");
    chkw(mem_wdata, '0, "rst_mem_wdata");
    chk1(done, 1'b0, "rst_done");
    @(posedge clk); #1;
    rstnn = 1'b1;
    @(posedge clk); #1;

    // Basic store, back-pressure, upstream gaps
    run_store(32'h0000_1000, 32'h20, 4'd8, 8, 10, 0, 0, 0, 8'h11);
    run_store(32'h0000_4000, 32'h40, 4'd8, 8, 0, 1, 0, 0, 8'h22);
    run_store(32'h0000_8000, 32'h10, 4'd8, 8, 0, 0, 1, 0, 8'h33);
    // Edge counts: zero rows, clamped count, address wrap
    run_store(32'h0000_5000, 32'h20, 4'd0, 0, 1, 0, 0, 0, 8'h44);
    run_store(32'h0000_6000, 32'h20, 4'd15, 8, 10, 0, 0, 0, 8'h55);
    run_store(32'hFFFF_FFF0, 32'h20, 4'd2, 2, 4, 0, 0, 0, 8'h66);
    // enable low after the 3rd pop
    run_store(32'h0000_7000, 32'h8, 4'd8, 8, 13, 0, 0, 1, 8'h77);

    // clear after the 5th pop
    start_inst(32'h0000_2000, 32'h10, 4'd8);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      store_tensor_row_rdata = row_data(8'h88, cyc - 1);
      @(negedge clk);
      chk1(store_tensor_row_rvalid, 1'b1, "clr_pre_pop");
      @(posedge clk); #1;
    end
    clear = 1'b1;
    @(negedge clk);
    chk1(store_tensor_row_rvalid, 1'b0, "clr_no_pop");
    chk1(done, 1'b0, "clr_done");
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk1(busy, 1'b0, "clr_busy");
    chk1(mem_wvalid, 1'b0, "clr_mem_wvalid");
    chk1(inst_wready, 1'b1, "clr_inst_wready");
    @(posedge clk); #1;
    run_store(32'h0000_3000, 32'h20, 4'd3, 3, 5, 0, 0, 0, 8'h99);

    // reset mid-run
    start_inst(32'h0000_9000, 32'h20, 4'd8);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      store_tensor_row_rdata = row_data(8'hAA, cyc - 1);
      @(negedge clk);
      chk1(store_tensor_row_rvalid, 1'b1, "rstmid_pre_pop");
      @(posedge clk); #1;
    end
    rstnn = 1'b0;
    @(negedge clk);
    chk1(store_tensor_row_rvalid, 1'b0, "rstmid_rvalid_now");
    chk1(inst_wready, 1'b0, "rstmid_inst_wready_now");
    @(posedge clk); #1;
    @(negedge clk);
    chk1(busy, 1'b0, "rstmid_busy");
    chk1(mem_wvalid, 1'b0, "rstmid_mem_wvalid");
    chk32(mem_waddr, 32'h0, "rstmid_mem_waddr");
    chkw(mem_wdata, '0, "rstmid_mem_wdata");
    chk1(done, 1'b0, "rstmid_done");
    chk1(store_tensor_row_rlast, 1'b0, "rstmid_rlast");
    @(posedge clk); #1;
    rstnn = 1'b1;
    @(posedge clk); #1;
    run_store(32'h0000_A000, 32'h4, 4'd2, 2, 4, 0, 0, 0, 8'hBB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
